// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection for the 5-stage MIPS core.
// Captures the decode control word, operands, register addresses and immediate,
// and inserts a bubble on a load-use hazard or a branch/jump flush.
// Optional build macro ID_EX_STALL_CNT_EN adds saturating hazard/flush event counters.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [8:0]        ctrl_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [1:0]        wb_o,
  output logic [1:0]        m_o,
  output logic [3:0]        ex_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [REG_AW-1:0] rs_addr_o,
  output logic [REG_AW-1:0] rt_addr_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              valid_o,
  output logic              hazard_stall_o
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]       hazard_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  logic [1:0]        wb_d;
  logic [1:0]        m_d;
  logic [3:0]        ex_d;
  logic [DATA_W-1:0] rs_data_d;
  logic [DATA_W-1:0] rt_data_d;
  logic [DATA_W-1:0] imm_d;
  logic [REG_AW-1:0] rs_addr_d;
  logic [REG_AW-1:0] rt_addr_d;
  logic [REG_AW-1:0] rd_addr_d;
  logic              valid_d;
  logic              bubble;

  // Load-use: the load in EX writes a register the instruction in ID reads.
  // Register zero is never a real dependency.
  always_comb begin
    hazard_stall_o = valid_i & valid_o & m_o[1] & (rt_addr_o != '0) &
                     ((rt_addr_o == rs_addr_i) | (rt_addr_o == rt_addr_i));
  end

  assign bubble = flush_i | hazard_stall_o;

  // Next-state: bubble zeroes everything, otherwise capture ID; control is
  // masked by valid_i so unknown bits on an empty slot never propagate.
  always_comb begin
    wb_d      = '0;
    m_d       = '0;
    ex_d      = '0;
    rs_data_d = '0;
    rt_data_d = '0;
    imm_d     = '0;
    rs_addr_d = '0;
    rt_addr_d = '0;
    rd_addr_d = '0;
    valid_d   = 1'b0;
    if (!bubble) begin
      valid_d   = valid_i;
      rs_data_d = rs_data_i;
      rt_data_d = rt_data_i;
      imm_d     = imm_i;
      rs_addr_d = rs_addr_i;
      rt_addr_d = rt_addr_i;
      rd_addr_d = rd_addr_i;
      if (valid_i) begin
        wb_d = ctrl_i[8:7];
        m_d  = ctrl_i[5:4];
        ex_d = ctrl_i[3:0];
      end
    end
  end

  // Pipeline register; hold_i freezes the whole stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_o      <= '0;
      m_o       <= '0;
      ex_o      <= '0;
      rs_data_o <= '0;
      rt_data_o <= '0;
      imm_o     <= '0;
      rs_addr_o <= '0;
      rt_addr_o <= '0;
      rd_addr_o <= '0;
      valid_o   <= 1'b0;
    end else if (!hold_i) begin
      wb_o      <= wb_d;
      m_o       <= m_d;
      ex_o      <= ex_d;
      rs_data_o <= rs_data_d;
      rt_data_o <= rt_data_d;
      imm_o     <= imm_d;
      rs_addr_o <= rs_addr_d;
      rt_addr_o <= rt_addr_d;
      rd_addr_o <= rd_addr_d;
      valid_o   <= valid_d;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  // Saturating event counters; a coincident flush and hazard bump both.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hazard_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else if (!hold_i) begin
      if (hazard_stall_o && (hazard_cnt_o != '1)) begin
        hazard_cnt_o <= hazard_cnt_o + 32'd1;
      end
      if (flush_i && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage MIPS core.
- Sits directly downstream of the decode control unit. Captures its 9-bit control word plus operands, register addresses and immediate every cycle, and presents them to EX/MEM/WB.
- Contains load-use hazard detection. Asserts a stall to PC and IF/ID, and inserts a bubble (all-zero control) on load-use, on branch/jump flush, or both.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 5, register address width

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  reset, asynchronous, active-high
ctrl_i  in  9  control word: [8] RegWrite, [7] MemtoReg, [6] unused, [5] MemRead, [4] MemWrite, [3] RegDst, [2:1] ALUOp, [0] ALUSrc
valid_i  in  1  IF/ID holds a real instruction
flush_i  in  1  taken branch/jump; squash instruction currently in ID
hold_i  in  1  downstream freeze; whole register keeps its value
rs_addr_i, rt_addr_i, rd_addr_i  in  REG_AW  ID register fields
rs_data_i, rt_data_i  in  DATA_W  register-file read data
imm_i  in  DATA_W  sign-extended immediate
wb_o  out  2  {RegWrite, MemtoReg}
m_o  out  2  {MemRead, MemWrite}
ex_o  out  4  {RegDst, ALUOp[1:0], ALUSrc}
rs_data_o, rt_data_o, imm_o  out  DATA_W  registered copies
rs_addr_o, rt_addr_o, rd_addr_o  out  REG_AW  registered copies
valid_o  out  1  EX slot holds a real instruction
hazard_stall_o  out  1  combinational; hold PC and IF/ID this cycle

Behaviour:
- Reset (async, rst_i=1): every registered output is 0; hazard_stall_o evaluates to 0 because valid_o=0. Reset mid-stall discards the pending bubble and any hazard.
- Hazard (combinational):
  - hazard_stall_o = valid_i & valid_o & m_o[1] & (rt_addr_o != 0) & (rt_addr_o == rs_addr_i | rt_addr_o == rt_addr_i).
  - hazard_stall_o does not depend on flush_i or hold_i.
- Next-state priority on each rising edge:
  1. hold_i=1: all registers keep their value.
  2. flush_i=1 or hazard_stall_o=1: load a bubble. wb_o, m_o, ex_o and valid_o are 0; data/address fields are 0.
  3. Otherwise: load the inputs.
     - wb_o = ctrl_i[8:7], m_o = ctrl_i[5:4], ex_o = ctrl_i[3:0].
     - valid_o = valid_i.
     - Data and address fields are copied from the inputs.
     - When valid_i=0, the control fields are forced to 0.
- Latency: one cycle from ID to outputs. A load-use hazard yields exactly one bubble: after the bubble, m_o[1]=0, so the stall self-clears the next cycle and the held instruction then loads.
- Flush and hazard in the same cycle: a single bubble is loaded. Each is counted separately under the optional feature.
- hold_i and hazard together: nothing changes; hazard_stall_o stays high until the hold releases and the bubble loads.
- ctrl_i[6] is ignored.
- No X propagation: x bits on ctrl_i while valid_i=0 are masked to 0.

Optional Feature:
Macro ID_EX_STALL_CNT_EN.
- Defined: adds outputs hazard_cnt_o[31:0] and flush_cnt_o[31:0].
  - Each counter increments on a clock edge where hold_i=0 and its cause (hazard_stall_o or flush_i) is 1.
  - Both counters saturate at 0xFFFFFFFF.
  - Both counters reset to 0 on rst_i.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Reset: assert rst_i between edges -> all outputs 0 immediately, before the next clock edge; hazard_stall_o=0.
- R-type pass-through: ctrl_i=9'b1_0_0_00_1_10_0, rs=3, rt=4, rd=5, rs_data=0x11, valid_i=1 -> next cycle wb_o=2'b10, m_o=2'b00, ex_o=4'b1100, rd_addr_o=5, rs_data_o=0x11, valid_o=1.
- Load-use:
  - Stimulus: lw with ctrl 9'b1_1_0_10_0_00_1 and rt=8, followed by an ID instruction with rs=8.
  - Response: hazard_stall_o=1 for one cycle; the next edge loads a bubble (valid_o=0, m_o=0); then stall=0 and the instruction loads.
  - With STALL_CNT_EN: hazard_cnt_o=1.
- Register zero: lw with rt=0, next instruction rs=0 -> hazard_stall_o stays 0; no bubble.
- Flush plus hazard in the same cycle -> one bubble.
  - With STALL_CNT_EN: hazard_cnt_o and flush_cnt_o each increment by 1.
- hold_i=1 for 3 cycles during a pending hazard -> outputs frozen and hazard_stall_o high throughout; the bubble loads on the first edge after hold_i drops.
